// File: rtl/morse_transmitter.sv
// morse_transmitter
// Plays a stored Morse bit-string (dot = 10, line = 1110, earliest symbol
// in the highest set bit) out serially, one bit per Morse unit, followed
// by an end-of-word gap. All outputs are registered.

module morse_transmitter #(
  parameter int WIDTH       = 20,
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int GAP_UNITS   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             morse_out,
  output logic             busy,
  output logic             done
);

  // Counter widths: smallest width that holds the terminal count, never 0.
  localparam int UNIT_W    = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int GAP_TOTAL = GAP_UNITS * UNIT_CYCLES;
  localparam int GAP_W     = (GAP_TOTAL > 1) ? $clog2(GAP_TOTAL) : 1;
  localparam int IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam bit HAS_GAP   = (GAP_UNITS > 0);

  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_TOTAL > 0) ? GAP_TOTAL - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state_q,   state_d;
  logic [WIDTH-1:0]  pattern_q, pattern_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [UNIT_W-1:0] unit_cnt_q, unit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              morse_q,   morse_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;

  logic [IDX_W-1:0]  lead_idx;
  logic              value_nonzero;
  logic [IDX_W-1:0]  bit_idx_dec;
  logic              unit_end;
  logic              gap_end;

  // Locate the leading 1 of the incoming pattern; it is the first bit sent.
  always_comb begin
    lead_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) begin
        lead_idx = IDX_W'(i);
      end
    end
  end

  assign value_nonzero = |value;
  assign bit_idx_dec   = bit_idx_q - IDX_W'(1);
  assign unit_end      = (unit_cnt_q == UNIT_LAST);
  assign gap_end       = (gap_cnt_q == GAP_LAST);

  // Next-state logic; outputs are computed for the upcoming state so that
  // the registered outputs line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    bit_idx_d  = bit_idx_q;
    unit_cnt_d = unit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    morse_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (value_nonzero) begin
            pattern_d  = value;
            bit_idx_d  = lead_idx;
            unit_cnt_d = '0;
            state_d    = S_SEND;
            morse_d    = value[lead_idx];
            busy_d     = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_SEND: begin
        busy_d = 1'b1;
        if (unit_end) begin
          unit_cnt_d = '0;
          if (bit_idx_q != '0) begin
            bit_idx_d = bit_idx_dec;
            morse_d   = pattern_q[bit_idx_dec];
          end else if (HAS_GAP) begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          unit_cnt_d = unit_cnt_q + UNIT_W'(1);
          morse_d    = pattern_q[bit_idx_q];
        end
      end

      S_GAP: begin
        if (gap_end) begin
          gap_cnt_d = '0;
          state_d   = S_DONE;
          done_d    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
          busy_d    = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset wins over any request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pattern_q  <= '0;
      bit_idx_q  <= '0;
      unit_cnt_q <= '0;
      gap_cnt_q  <= '0;
      morse_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      bit_idx_q  <= bit_idx_d;
      unit_cnt_q <= unit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      morse_q    <= morse_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign morse_out = morse_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
